// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data-memory responder.
//   dmem_state_e      - responder FSM states (sweep clear, idle/serving)
//   BASE_ADDR_DEFAULT - default byte address of word 0
//   NUM_LANES/LANE_W  - byte-lane organisation of each memory word
package dmem_pkg;

    typedef enum logic [0:0] {
        StClear,
        StIdle
    } dmem_state_e;

    localparam logic [31:0] BASE_ADDR_DEFAULT = 32'h0000_0000;
    localparam int unsigned NUM_LANES         = 4;
    localparam int unsigned LANE_W            = 8;

endpackage

// File: rtl/byte_lane_ram.sv
// byte_lane_ram: one 8-bit lane of the data memory, DEPTH = 2**ADDR_W entries.
//   clk        - clock
//   rst        - synchronous active-high reset (read register only)
//   wr_en_i    - write enable for this lane
//   wr_addr_i  - write word index
//   wr_data_i  - write byte
//   rd_en_i    - load the read register from the array (write-first)
//   rd_zero_i  - load the read register with zero
//   rd_addr_i  - read word index
//   rd_data_o  - registered read byte; holds when no read is requested
module byte_lane_ram #(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [7:0]        wr_data_i,
    input  logic              rd_en_i,
    input  logic              rd_zero_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [7:0]        rd_data_o
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [7:0] mem_q [DEPTH];
    logic [7:0] rd_data_q;

    // Array contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Write-first: a same-cycle write to the read address is forwarded.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= 8'h00;
        end else if (rd_zero_i) begin
            rd_data_q <= 8'h00;
        end else if (rd_en_i) begin
            if (wr_en_i && (wr_addr_i == rd_addr_i)) begin
                rd_data_q <= wr_data_i;
            end else begin
                rd_data_q <= mem_q[rd_addr_i];
            end
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/dmem_resp.sv
// dmem_resp: data-memory responder for the core's load/store interface.
//   clk, rst        - clock, synchronous active-high reset
//   mem_rd_req_i    - load request; mem_rd_addr_i byte address (bits [1:0] ignored)
//   mem_rd_data_o   - load data, valid one clock after the request, held otherwise
//   mem_wr_req_i    - store request; mem_wr_sel_i byte lanes, mem_wr_addr_i, mem_wr_data_i
//   ready_o         - high when serving requests, low during the zero-fill sweep
//   err_o           - sticky out-of-range flag
//   err_addr_o      - byte address of the first out-of-range access
module dmem_resp
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W         = 10,
    parameter logic [31:0] BASE_ADDR      = BASE_ADDR_DEFAULT,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_rd_req_i,
    input  logic [31:0] mem_rd_addr_i,
    output logic [31:0] mem_rd_data_o,
    input  logic        mem_wr_req_i,
    input  logic [3:0]  mem_wr_sel_i,
    input  logic [31:0] mem_wr_addr_i,
    input  logic [31:0] mem_wr_data_i,
    output logic        ready_o,
    output logic        err_o,
    output logic [31:0] err_addr_o
);

    localparam int unsigned DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(DEPTH - 1);

    dmem_state_e       state_q;
    logic [ADDR_W-1:0] cnt_q;
    logic              ready_q;
    logic              err_q;
    logic [31:0]       err_addr_q;

    logic [31:0]       wr_off;
    logic [31:0]       rd_off;
    logic              wr_in_range;
    logic              rd_in_range;
    logic              clearing;
    logic              serving;
    logic              wr_bad;
    logic              rd_bad;
    logic              err_hit;
    logic [31:0]       err_addr_d;

    logic [NUM_LANES-1:0] lane_we;
    logic [ADDR_W-1:0]    ram_wr_addr;
    logic [31:0]          ram_wr_data;
    logic                 ram_rd_en;
    logic                 ram_rd_zero;

    // Offsets wrap, so addresses below BASE_ADDR land far out of range.
    assign wr_off      = mem_wr_addr_i - BASE_ADDR;
    assign rd_off      = mem_rd_addr_i - BASE_ADDR;
    assign wr_in_range = (wr_off[31:ADDR_W+2] == '0);
    assign rd_in_range = (rd_off[31:ADDR_W+2] == '0);

    logic unused_off;
    assign unused_off = ^{wr_off[1:0], rd_off[1:0]};

    assign clearing = (state_q == StClear);
    assign serving  = (state_q == StIdle);

    assign wr_bad  = serving && mem_wr_req_i && !wr_in_range;
    assign rd_bad  = serving && mem_rd_req_i && !rd_in_range;
    assign err_hit = wr_bad || rd_bad;

    always_comb begin
        err_addr_d = mem_rd_addr_i;
        if (wr_bad) begin
            err_addr_d = mem_wr_addr_i;
        end
    end

    // Write port is shared between the sweep and core stores; rst blocks both.
    always_comb begin
        lane_we     = '0;
        ram_wr_addr = wr_off[ADDR_W+1:2];
        ram_wr_data = mem_wr_data_i;
        if (!rst) begin
            if (clearing) begin
                lane_we     = '1;
                ram_wr_addr = cnt_q;
                ram_wr_data = 32'h0;
            end else if (serving && mem_wr_req_i && wr_in_range) begin
                lane_we = mem_wr_sel_i;
            end
        end
    end

    assign ram_rd_en   = !rst && serving && mem_rd_req_i && rd_in_range;
    assign ram_rd_zero = !rst && rd_bad;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        byte_lane_ram #(
            .ADDR_W (ADDR_W)
        ) u_lane (
            .clk       (clk),
            .rst       (rst),
            .wr_en_i   (lane_we[i]),
            .wr_addr_i (ram_wr_addr),
            .wr_data_i (ram_wr_data[LANE_W*i +: LANE_W]),
            .rd_en_i   (ram_rd_en),
            .rd_zero_i (ram_rd_zero),
            .rd_addr_i (rd_off[ADDR_W+1:2]),
            .rd_data_o (mem_rd_data_o[LANE_W*i +: LANE_W])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= CLEAR_ON_RESET ? StClear : StIdle;
            cnt_q      <= '0;
            ready_q    <= !CLEAR_ON_RESET;
            err_q      <= 1'b0;
            err_addr_q <= 32'h0;
        end else begin
            unique case (state_q)
                StClear: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LastIdx) begin
                        state_q <= StIdle;
                        ready_q <= 1'b1;
                    end
                end
                StIdle: begin
                    // Only the first error is captured.
                    if (!err_q && err_hit) begin
                        err_q      <= 1'b1;
                        err_addr_q <= err_addr_d;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign ready_o    = ready_q;
    assign err_o      = err_q;
    assign err_addr_o = err_addr_q;

endmodule

// File: tb/tb_dmem_resp.sv
module tb_dmem_resp;

    localparam int unsigned AW    = 4;
    localparam int unsigned WORDS = 2 ** AW;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_rd_req_i = 1'b0;
    logic [31:0] mem_rd_addr_i = 32'h0;
    logic [31:0] mem_rd_data_o;
    logic        mem_wr_req_i = 1'b0;
    logic [3:0]  mem_wr_sel_i = 4'h0;
    logic [31:0] mem_wr_addr_i = 32'h0;
    logic [31:0] mem_wr_data_i = 32'h0;
    logic        ready_o;
    logic        err_o;
    logic [31:0] err_addr_o;

    always #5 clk = ~clk;

    dmem_resp #(
        .ADDR_W         (AW),
        .BASE_ADDR      (32'h0000_0000),
        .CLEAR_ON_RESET (1'b1)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .mem_rd_req_i  (mem_rd_req_i),
        .mem_rd_addr_i (mem_rd_addr_i),
        .mem_rd_data_o (mem_rd_data_o),
        .mem_wr_req_i  (mem_wr_req_i),
        .mem_wr_sel_i  (mem_wr_sel_i),
        .mem_wr_addr_i (mem_wr_addr_i),
        .mem_wr_data_i (mem_wr_data_i),
        .ready_o       (ready_o),
        .err_o         (err_o),
        .err_addr_o    (err_addr_o)
    );

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    logic [31:0] model [WORDS];
    logic [31:0] exp_q [$];
    logic [31:0] last_rd = 32'h0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic bit in_range(input logic [31:0] a);
        return a < 32'(WORDS * 4);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < WORDS; i++) model[i] = 32'h0;
    endtask

    // One idle-state cycle: drive, update model (store before load), check after edge.
    task automatic step(input string tag, input logic rd, input logic [31:0] ra,
                        input logic wr, input logic [3:0] sel, input logic [31:0] wa,
                        input logic [31:0] wd);
        logic [31:0] w;
        logic [31:0] exp;
        mem_rd_req_i  = rd;
        mem_rd_addr_i = ra;
        mem_wr_req_i  = wr;
        mem_wr_sel_i  = sel;
        mem_wr_addr_i = wa;
        mem_wr_data_i = wd;
        if (wr && in_range(wa)) begin
            w = model[wa[AW+1:2]];
            for (int k = 0; k < 4; k++) if (sel[k]) w[8*k +: 8] = wd[8*k +: 8];
            model[wa[AW+1:2]] = w;
        end
        if (rd) begin
            exp = in_range(ra) ? model[ra[AW+1:2]] : 32'h0;
            exp_q.push_back(exp);
        end
        @(posedge clk);
        #1;
        mem_rd_req_i = 1'b0;
        mem_wr_req_i = 1'b0;
        if (rd) begin
            exp = exp_q.pop_front();
            check(tag, mem_rd_data_o, exp);
            last_rd = exp;
        end else begin
            check({tag, "_hold"}, mem_rd_data_o, last_rd);
        end
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!ready_o && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(tag, 32'(n), 32'd16);
    endtask

    initial begin
        model_clear();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", {31'b0, ready_o}, 32'd0);
        check("rst_err", {31'b0, err_o}, 32'd0);
        check("rst_err_addr", err_addr_o, 32'h0);
        check("rst_rd_data", mem_rd_data_o, 32'h0);
        rst = 1'b0;

        // Store during the sweep must be ignored.
        @(posedge clk);
        #1;
        mem_wr_req_i  = 1'b1;
        mem_wr_sel_i  = 4'hF;
        mem_wr_addr_i = 32'h0;
        mem_wr_data_i = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        mem_wr_req_i = 1'b0;
        check("sweep_ready_low", {31'b0, ready_o}, 32'd0);
        begin
            int n;
            n = 2;
            while (!ready_o && n < 100) begin
                @(posedge clk);
                #1;
                n++;
            end
            check("sweep_len", 32'(n), 32'd16);
        end
        check("sweep_no_err", {31'b0, err_o}, 32'd0);

        for (int i = 0; i < WORDS; i++) step("sweep_zero", 1'b1, 32'(i * 4), 1'b0, 4'h0, 0, 0);

        step("st_full", 1'b0, 0, 1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF);
        step("st_lo", 1'b0, 0, 1'b1, 4'b0011, 32'h10, 32'h0000_55AA);
        step("ld_lanes", 1'b1, 32'h10, 1'b0, 4'h0, 0, 0);
        step("idle", 1'b0, 0, 1'b0, 4'h0, 0, 0);

        step("st_aa", 1'b0, 0, 1'b1, 4'hF, 32'h20, 32'hAAAA_AAAA);
        step("fwd", 1'b1, 32'h20, 1'b1, 4'b1100, 32'h20, 32'h1234_5678);
        step("diff_word", 1'b1, 32'h10, 1'b1, 4'hF, 32'h24, 32'h0BAD_F00D);
        step("ld_24", 1'b1, 32'h27, 1'b0, 4'h0, 0, 0);
        step("sel_none", 1'b0, 0, 1'b1, 4'h0, 32'h24, 32'hFFFF_FFFF);
        step("ld_24b", 1'b1, 32'h24, 1'b0, 4'h0, 0, 0);

        check("no_err_yet", {31'b0, err_o}, 32'd0);
        step("oor_st", 1'b0, 0, 1'b1, 4'hF, 32'h40, 32'h5555_5555);
        step("oor_ld", 1'b1, 32'h80, 1'b0, 4'h0, 0, 0);
        check("oor_err", {31'b0, err_o}, 32'd1);
        check("oor_err_addr", err_addr_o, 32'h40);
        step("alias_0", 1'b1, 32'h0, 1'b0, 4'h0, 0, 0);
        step("oor_ld2", 1'b1, 32'hFFFF_FFFC, 1'b0, 4'h0, 0, 0);
        check("err_addr_sticky", err_addr_o, 32'h40);

        // Reset mid-idle, then again mid-sweep at counter 7.
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst2_err", {31'b0, err_o}, 32'd0);
        check("rst2_err_addr", err_addr_o, 32'h0);
        check("rst2_rd_data", mem_rd_data_o, 32'h0);
        check("rst2_ready", {31'b0, ready_o}, 32'd0);
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        wait_ready("midsweep_len");
        model_clear();
        last_rd = 32'h0;
        step("clr_10", 1'b1, 32'h10, 1'b0, 4'h0, 0, 0);
        step("clr_3c", 1'b1, 32'h3C, 1'b0, 4'h0, 0, 0);

        // Both ports out of range in one cycle: store address is captured.
        step("both_oor", 1'b1, 32'h84, 1'b1, 4'hF, 32'h44, 32'h1);
        check("both_oor_addr", err_addr_o, 32'h44);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
